ram_bus_ptr: RTL and testbench

- Parametrised successor to the 4-bit processor RAM: a word-addressed memory on the shared tri-state data bus, controlled by the microcode instruction word.
- Adds configurable data width and depth, an internal address pointer with auto-increment/decrement access modes, registered one-cycle read drive, and a bus-collision rule.
- Sits between the control sequencer (instr) and the common data bus, alongside the register and ALU blocks.

---
 rtl/ram_bus_ptr_pkg.sv | 32 +++
 rtl/ram_bus_ptr_agu.sv | 53 +++++
 rtl/ram_bus_ptr.sv | 107 ++++++++++
 tb/tb_ram_bus_ptr.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_bus_ptr_pkg.sv
// Shared definitions for the pointer-addressed bus RAM: op encodings,
// instruction field layout and default geometry.
package ram_bus_ptr_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    OP_DIRECT = 2'b00,
    OP_LDPTR  = 2'b01,
    OP_INC    = 2'b10,
    OP_DEC    = 2'b11
  } op_e;

  // Control field bit offsets, counted from the top of the addr field.
  localparam int INSTR_WE_OFS    = 0;
  localparam int INSTR_OP_LO_OFS = 1;
  localparam int INSTR_OP_HI_OFS = 2;
  localparam int INSTR_EN_OFS    = 3;
  localparam int INSTR_CTRL_W    = 4;

  typedef struct packed {
    logic en;
    op_e  op;
    logic we;
  } ctrl_t;

  function automatic logic op_is_access(input op_e op);
    return op != OP_LDPTR;
  endfunction

endpackage

// File: rtl/ram_bus_ptr_agu.sv
// Address generation unit: owns the access pointer, selects the effective
// address and applies modulo-depth increment/decrement.
module ram_bus_ptr_agu
  import ram_bus_ptr_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [1:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] ea_o,
  output logic [ADDR_W-1:0] ptr_o
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  // Natural ADDR_W-bit overflow gives the required wrap in both directions.
  always_comb begin
    ptr_d = ptr_q;
    ea_o  = addr_i;
    if (en_i) begin
      case (op_e'(op_i))
        OP_DIRECT: ea_o  = addr_i;
        OP_LDPTR:  ptr_d = addr_i;
        OP_INC: begin
          ea_o  = ptr_q;
          ptr_d = ptr_q + ONE;
        end
        OP_DEC: begin
          ea_o  = ptr_q;
          ptr_d = ptr_q - ONE;
        end
        default: ptr_d = ptr_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/ram_bus_ptr.sv
// Word-addressed RAM on the shared tri-state bus with pointer access modes.
// Optional even-parity protection is compiled in with RAM_PARITY_EN.
module ram_bus_ptr
  import ram_bus_ptr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W+INSTR_CTRL_W-1:0] instr,
  inout  wire  [DATA_W-1:0]          bus,
  output logic                       rd_valid,
  output logic [ADDR_W-1:0]          ptr,
  output logic                       err
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  ctrl_t             ctrl;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] ea;
  logic              access;
  logic              wr_cmd;
  logic              rd_cmd;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;

  logic [MEM_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic              rd_valid_q;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  assign ctrl   = ctrl_t'(instr[ADDR_W +: INSTR_CTRL_W]);
  assign addr   = instr[ADDR_W-1:0];
  assign access = ctrl.en && op_is_access(ctrl.op);
  assign wr_cmd = access && ctrl.we;
  assign rd_cmd = access && !ctrl.we;

  ram_bus_ptr_agu #(
    .ADDR_W (ADDR_W)
  ) u_agu (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (ctrl.en),
    .op_i   (ctrl.op),
    .addr_i (addr),
    .ea_o   (ea),
    .ptr_o  (ptr)
  );

`ifdef RAM_PARITY_EN
  assign wr_word = {even_parity(bus), bus};
`else
  assign wr_word = bus;
`endif

  // Array is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (rst && wr_cmd) begin
      mem_q[ea] <= wr_word;
    end
  end

  assign rd_word = mem_q[ea];

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_q       <= '0;
    end else begin
      rd_valid_q <= rd_cmd;
      if (rd_cmd) begin
        rd_q <= rd_word[DATA_W-1:0];
      end
    end
  end

`ifdef RAM_PARITY_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (rd_cmd && (even_parity(rd_word[DATA_W-1:0]) != rd_word[DATA_W])) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // A write arriving while read data is on the bus wins: release immediately.
  assign bus      = (rd_valid_q && !wr_cmd) ? rd_q : {DATA_W{1'bz}};
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ram_bus_ptr.sv
// Bench for ram_bus_ptr: directed plan plus random commands against a
// behavioural memory/pointer model. Parity checks build with RAM_PARITY_EN.
module tb_ram_bus_ptr;
  import ram_bus_ptr_pkg::*;

  localparam int DW    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW+3:0] instr;
  wire  [DW-1:0] bus;
  logic          rd_valid;
  logic [AW-1:0] ptr;
  logic          err;

  logic          drv_en;
  logic [DW-1:0] drv_val;

  always #5 clk = ~clk;

  assign bus = drv_en ? drv_val : {DW{1'bz}};

  ram_bus_ptr #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .instr    (instr),
    .bus      (bus),
    .rd_valid (rd_valid),
    .ptr      (ptr),
    .err      (err)
  );

  int checks = 0;
  int fails  = 0;

  logic [DW-1:0] m_mem     [DEPTH];
  bit            m_known   [DEPTH];
  bit            m_corrupt [DEPTH];
  int            m_ptr;
  bit            m_valid;
  logic [DW-1:0] m_data;
  bit            m_data_known;
  bit            m_err;

  logic          cur_rst;
  logic [7:0]    cur_ins;
  logic [DW-1:0] cur_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mk(input logic en, input logic [1:0] op,
                                    input logic we, input logic [3:0] a);
    return {en, op, we, a};
  endfunction

  function automatic bit is_write(input logic [7:0] ins);
    return ins[7] && ins[4] && (ins[6:5] != 2'b01);
  endfunction

  task automatic apply(input logic r, input logic [7:0] ins, input logic [DW-1:0] d);
    @(negedge clk);
    rst     = r;
    instr   = ins;
    drv_en  = is_write(ins);
    drv_val = d;
    cur_rst = r;
    cur_ins = ins;
    cur_d   = d;
  endtask

  // Model the effect of the command at the edge, then compare outputs.
  task automatic commit(input string tag);
    bit         en, we;
    logic [1:0] op;
    int         a, ea;
    @(posedge clk);
    en = cur_ins[7];
    op = cur_ins[6:5];
    we = cur_ins[4];
    a  = int'(cur_ins[3:0]);
    if (!cur_rst) begin
      m_ptr   = 0;
      m_valid = 0;
      m_err   = 0;
    end else if (!en) begin
      m_valid = 0;
    end else if (op == 2'b01) begin
      m_ptr   = a;
      m_valid = 0;
    end else begin
      ea = (op == 2'b00) ? a : m_ptr;
      if (op == 2'b10) m_ptr = (m_ptr + 1) % DEPTH;
      if (op == 2'b11) m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
      if (we) begin
        m_mem[ea]     = cur_d;
        m_known[ea]   = 1;
        m_corrupt[ea] = 0;
        m_valid       = 0;
      end else begin
        m_valid      = 1;
        m_data       = m_mem[ea];
        m_data_known = m_known[ea];
        if (m_corrupt[ea]) m_err = 1;
      end
    end
    #1;
    chk({tag, ".ptr"}, 32'(ptr), 32'(m_ptr));
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_valid));
`ifdef RAM_PARITY_EN
    chk({tag, ".err"}, 32'(err), 32'(m_err));
`else
    chk({tag, ".err"}, 32'(err), 32'(0));
`endif
    if (m_valid && m_data_known) chk({tag, ".bus"}, 32'(bus), 32'(m_data));
  endtask

  task automatic step(input string tag, input logic r, input logic [7:0] ins,
                      input logic [DW-1:0] d);
    apply(r, ins, d);
    commit(tag);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_known[i]   = 0;
      m_corrupt[i] = 0;
      m_mem[i]     = '0;
    end
    m_ptr = 0; m_valid = 0; m_data = '0; m_data_known = 0; m_err = 0;
    rst = 1'b0; instr = '0; drv_en = 1'b0; drv_val = '0;

    // Reset, including a read that the reset must override.
    step("rst_a", 1'b0, 8'h00, 4'h0);
    step("rst_b", 1'b0, mk(1, 2'b10, 0, 4'h3), 4'h0);

    // Direct write then read of addr 1; bus released afterwards.
    step("wr1",  1'b1, mk(1, 2'b00, 1, 4'h1), 4'h4);
    step("rd1",  1'b1, mk(1, 2'b00, 0, 4'h1), 4'h0);
    step("idle", 1'b1, 8'h00, 4'h0);

    // Increment burst across the top of the array.
    step("ld14", 1'b1, mk(1, 2'b01, 0, 4'hE), 4'h0);
    step("incA", 1'b1, mk(1, 2'b10, 1, 4'h0), 4'hA);
    step("incB", 1'b1, mk(1, 2'b10, 1, 4'h0), 4'hB);
    step("incC", 1'b1, mk(1, 2'b10, 1, 4'h0), 4'hC);
    step("rd14", 1'b1, mk(1, 2'b00, 0, 4'hE), 4'h0);
    step("rd15", 1'b1, mk(1, 2'b00, 0, 4'hF), 4'h0);
    step("rd0",  1'b1, mk(1, 2'b00, 0, 4'h0), 4'h0);

    // Decrement reads wrapping below zero.
    step("ld0",  1'b1, mk(1, 2'b01, 0, 4'h0), 4'h0);
    step("dec0", 1'b1, mk(1, 2'b11, 0, 4'h0), 4'h0);
    step("dec1", 1'b1, mk(1, 2'b11, 0, 4'h0), 4'h0);

    // Collision: write right after a read; external data must win.
    step("wr3",  1'b1, mk(1, 2'b00, 1, 4'h3), 4'h2);
    step("rd3",  1'b1, mk(1, 2'b00, 0, 4'h3), 4'h0);
    apply(1'b1, mk(1, 2'b00, 1, 4'h5), 4'h9);
    #1;
    chk("coll.bus", 32'(bus), 32'(4'h9));
    chk("coll.rd_valid", 32'(rd_valid), 32'(1));
    commit("coll");
    step("rd5",  1'b1, mk(1, 2'b00, 0, 4'h5), 4'h0);

    // Reset in the middle of a burst; contents retained.
    step("wr2",   1'b1, mk(1, 2'b00, 1, 4'h2), 4'h7);
    step("ldb",   1'b1, mk(1, 2'b01, 0, 4'h8), 4'h0);
    step("burst", 1'b1, mk(1, 2'b10, 0, 4'h0), 4'h0);
    step("midrst", 1'b0, mk(1, 2'b10, 0, 4'h0), 4'h0);
    step("rd2",   1'b1, mk(1, 2'b00, 0, 4'h2), 4'h0);

    for (int i = 0; i < 400; i++) begin
      logic          r;
      logic [7:0]    ins;
      logic [DW-1:0] d;
      r   = ($urandom_range(0, 31) != 0);
      ins = 8'($urandom);
      d   = DW'($urandom);
      step("rand", r, ins, d);
    end

`ifdef RAM_PARITY_EN
    step("pwr6", 1'b1, mk(1, 2'b00, 1, 4'h6), 4'h5);
    @(negedge clk);
    dut.mem_q[6][0] = ~dut.mem_q[6][0];
    m_mem[6]     = m_mem[6] ^ 4'h1;
    m_corrupt[6] = 1;
    step("prd6",  1'b1, mk(1, 2'b00, 0, 4'h6), 4'h0);
    chk("perr.set", 32'(err), 32'(1));
    step("pidle", 1'b1, 8'h00, 4'h0);
    chk("perr.sticky", 32'(err), 32'(1));
    step("prst",  1'b0, 8'h00, 4'h0);
    chk("perr.clear", 32'(err), 32'(0));
`endif

    step("end", 1'b1, 8'h00, 4'h0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
